// File: rtl/usb_link_ctrl.sv
// USB device link-layer controller: line sync/decode, device state tracking, bus-reset detect, TX FIFO.
// Define USB_LINK_STATS_EN to enable the saturating drop_cnt statistic; otherwise drop_cnt reads 0.
module usb_link_ctrl #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_EP       = 4,
  parameter int RESET_CYCLES = 120,
  localparam int EP_W        = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vbus,
  input  logic              d_p,
  input  logic              d_n,
  input  logic              cfg_done,
  input  logic [NUM_EP-1:0] ep_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EP_W-1:0]   in_ep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EP_W-1:0]   out_ep,
  output logic [2:0]        dev_state,
  output logic [1:0]        line_state,
  output logic              bus_reset,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [15:0]       drop_cnt
);

  // state         | meaning
  // ST_DETACHED   | no VBUS seen
  // ST_POWERED    | VBUS present, awaiting first bus reset
  // ST_DEFAULT    | bus reset seen, awaiting SET_CONFIGURATION
  // ST_CONFIGURED | configured, TX FIFO active
  // ST_ERROR      | SE1 seen; left only by bus reset or VBUS loss
  typedef enum logic [2:0] {
    ST_DETACHED   = 3'd0,
    ST_POWERED    = 3'd1,
    ST_DEFAULT    = 3'd2,
    ST_CONFIGURED = 3'd3,
    ST_ERROR      = 3'd4
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  state_t state, state_nxt;
  logic vbus_s1, vbus_s2, dp_s1, dp_s2, dn_s1, dn_s2;
  logic se0, se1, se1_prev;
  logic [CNT_W-1:0] se0_cnt;
  logic cfg, flush, ep_ok, push, pop, full, empty;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [EP_W-1:0]   mem_ep   [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      {vbus_s1, vbus_s2, dp_s1, dp_s2, dn_s1, dn_s2} <= '0;
    end else begin
      vbus_s1 <= vbus;
      vbus_s2 <= vbus_s1;
      dp_s1   <= d_p;
      dp_s2   <= dp_s1;
      dn_s1   <= d_n;
      dn_s2   <= dn_s1;
    end
  end

  assign line_state = {dn_s2, dp_s2};
  assign se0 = (line_state == 2'd0);
  assign se1 = (line_state == 2'd3);

  // bus_reset is registered so it coincides with the counter reaching RESET_CYCLES
  always_ff @(posedge clk) begin
    if (!rst) begin
      se0_cnt   <= '0;
      bus_reset <= 1'b0;
      se1_prev  <= 1'b0;
    end else begin
      bus_reset <= se0 && (se0_cnt == CNT_W'(RESET_CYCLES - 1));
      se1_prev  <= se1;
      if (!se0)
        se0_cnt <= '0;
      else if (se0_cnt != CNT_W'(RESET_CYCLES))
        se0_cnt <= se0_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_DETACHED;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!vbus_s2)
      state_nxt = ST_DETACHED;
    else if (bus_reset && (state != ST_DETACHED))
      state_nxt = ST_DEFAULT;
    else if (se1 && se1_prev && ((state == ST_DEFAULT) || (state == ST_CONFIGURED)))
      state_nxt = ST_ERROR;
    else if (state == ST_DETACHED)
      state_nxt = ST_POWERED;
    else if ((state == ST_DEFAULT) && cfg_done)
      state_nxt = ST_CONFIGURED;

    cfg   = (state == ST_CONFIGURED);
    flush = cfg && (state_nxt != ST_CONFIGURED);
  end

  assign dev_state = state;

  // out-of-range endpoint numbers never match, so they count as disabled
  always_comb begin
    ep_ok = 1'b0;
    for (int i = 0; i < NUM_EP; i++)
      if (in_ep == EP_W'(i)) ep_ok = ep_en[i];
  end

  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty     = (fifo_level == '0);
  assign in_ready  = cfg && !full;
  assign out_valid = cfg && !empty;
  assign push      = in_valid && in_ready && ep_ok;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_ep    = out_valid ? mem_ep[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_ep[wr_ptr]   <= in_ep;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef USB_LINK_STATS_EN
  logic drop;
  logic [15:0] drop_q;

  assign drop = in_valid && in_ready && !ep_ok;

  always_ff @(posedge clk) begin
    if (!rst || bus_reset)
      drop_q <= '0;
    else if (drop && (drop_q != 16'hFFFF))
      drop_q <= drop_q + 1'b1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule
